num_rom_reader: RTL and testbench
=================================

// Module: num_rom_reader
// PURPOSE
//  Read-side sequencer for the glyph/number ROM. Accepts a glyph index request, issues ROWS_PER_GLYPH
//  consecutive ROM addresses, absorbs the ROM's fixed read latency and delivers each row on a
//  valid/ready stream with last-row marking. Sits between the display/overlay logic and the ROM instance.
// PARAMETERS
//  ADDR_WIDTH      10  ROM address width; must equal the ROM instance's address width
//  DATA_WIDTH      32  ROM data width = output row width
//  ROWS_LOG2       4   log2(rows per glyph); rows per glyph R = 2**ROWS_LOG2
//  RD_LATENCY      1   ROM addr-to-data cycles: 1 = no output register, 2 = output register enabled
//  FIFO_DEPTH      4   output buffer entries; must be >= RD_LATENCY+1
//  Derived: IDX_W = ADDR_WIDTH-ROWS_LOG2
// PORTS
//  clk           in   1            system clock; ROM is clocked by the same clk
//  rst_n         in   1            asynchronous active-low reset
//  req_valid     in   1            glyph request valid
//  req_ready     out  1            request accepted when req_valid&req_ready
//  req_idx       in   IDX_W        glyph index
//  rom_addr      out  ADDR_WIDTH   to ROM addr
//  rom_clk_en    out  1            to ROM clk_en; high when an address is issued or data in flight
//  rom_rd_data   in   DATA_WIDTH   from ROM rd_data
//  out_valid     out  1            row valid
//  out_ready     in   1            downstream accepts row
//  out_data      out  DATA_WIDTH   row data
//  out_last      out  1            high with final row of glyph
//  busy          out  1            high from request accept until last row handshaken
// BEHAVIOUR
//  Reset: req_ready=0 during reset, 1 on first cycle after; rom_addr=0, rom_clk_en=0, out_valid=0,
//   out_data=0, out_last=0, busy=0; FIFO, in-flight pipe, counters cleared.
//  FSM IDLE->FETCH->DRAIN->IDLE. req_ready=1 only in IDLE.
//   IDLE: on req_valid, latch req_idx, row_cnt=0, busy=1, go FETCH.
//   FETCH: issue when credit available: in_flight + fifo_count < FIFO_DEPTH. Issue = drive
//    rom_addr={idx,row_cnt}, set in-flight pipe stage 0 with last=(row_cnt==R-1), row_cnt++.
//    After issuing row R-1 go DRAIN. No issue without credit (no stalls lost, no overflow).
//   DRAIN: wait until in-flight pipe empty and last row popped from FIFO, then IDLE, busy=0.
//  Latency: RD_LATENCY-deep valid/last shift pipe; when tag exits, rom_rd_data pushed to FIFO same cycle.
//   With empty FIFO and out_ready=1, first row out_valid at RD_LATENCY+1 cycles after request accept;
//   throughput 1 row/cycle sustained.
//  FIFO: first-word registered output; out_data/out_last stable while out_valid&!out_ready.
//   Simultaneous push and pop on full FIFO legal only because credit forbids push when full: never occurs.
//  rom_addr holds last issued value when not issuing (no glitch to 0).
//  out_ready low indefinitely: issuing stops once credits exhausted; no data dropped.
//  Back-to-back requests: next request not accepted until IDLE (one cycle gap min after last handshake).
//  req_idx sampled only on accept; later changes ignored.
//  Reset mid-glyph: all state cleared asynchronously; partial glyph discarded, no out_last emitted.
//  Parameter check: elaboration error if FIFO_DEPTH < RD_LATENCY+1 or RD_LATENCY not in {1,2}.
// STRUCTURE
//  Shared package num_rom_pkg: state enum {IDLE,FETCH,DRAIN}, ROM geometry constants
//   (ADDR_WIDTH, DATA_WIDTH, ROWS_LOG2) shared with the ROM wrapper instance.
//  One sub-module: num_rom_reader_fifo (sync FIFO, width DATA_WIDTH+1, depth FIFO_DEPTH, count output).
//  Top: FSM, row counter, credit counter, latency pipe.
// TESTING
//  ROM model with init file mem[a]=a*3; RD_LATENCY 1 and 2 both run.
//  1 Reset: rst_n=0 mid-run -> all outputs 0 next edge; after release req_ready=1, busy=0.
//  2 idx=5, ROWS_LOG2=4, out_ready=1 -> addrs 80..95 issued; rows 240..285 step 3, out_last on row 285,
//    first out_valid at cycle RD_LATENCY+1 after accept, 16 consecutive beats.
//  3 idx=2, out_ready=0 for 20 cycles -> exactly FIFO_DEPTH addresses issued, no overflow; release ->
//    16 rows in order, values 96..141 step 3.
//  4 Random out_ready (50%) over idx=0..63 -> scoreboard matches, one out_last per glyph, data stable under stall.
//  5 req_valid held with idx=7 while busy -> no accept until IDLE; idx changed mid-glyph ignored.
//  6 rst_n asserted after 6 rows of idx=3 -> no out_last, new request idx=1 afterwards yields clean 16 rows.

Source files
------------

// File: rtl/num_rom_pkg.sv
// Shared definitions for the glyph/number ROM and its read-side sequencer.
package num_rom_pkg;

    localparam int unsigned ROM_ADDR_WIDTH = 10;
    localparam int unsigned ROM_DATA_WIDTH = 32;
    localparam int unsigned ROM_ROWS_LOG2  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/num_rom_reader_fifo.sv
// Synchronous FIFO with a registered head entry (first word appears on rd_data) and an occupancy count.
module num_rom_reader_fifo #(
    parameter int unsigned  WIDTH = 33,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count_c
);
    // The head register is one of the DEPTH entries; the array holds the rest.
    localparam int unsigned MEM_D = DEPTH - 1;
    localparam int unsigned PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [MEM_D];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             pop, mem_wr, mem_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MEM_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop        = head_vld_q & rd_ready;
        mem_rd     = pop & (mem_cnt_q != '0);
        mem_wr     = wr_en & head_vld_q & (~pop | (mem_cnt_q != '0));
        head_vld_d = head_vld_q;
        head_d     = head_q;
        // Refill the head from the array first, otherwise bypass the incoming word.
        if (!head_vld_q || pop) begin
            if (mem_rd) begin
                head_vld_d = 1'b1;
                head_d     = mem_q[rd_ptr_q];
            end else if (wr_en) begin
                head_vld_d = 1'b1;
                head_d     = wr_data;
            end else begin
                head_vld_d = 1'b0;
            end
        end
        wr_ptr_d  = mem_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = mem_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + CNT_W'(mem_wr) - CNT_W'(mem_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q <= 1'b0;
            head_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            for (int i = 0; i < int'(MEM_D); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            if (mem_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

    assign rd_valid = head_vld_q;
    assign rd_data  = head_q;
    assign count_c  = mem_cnt_q + CNT_W'(head_vld_q);

endmodule

// File: rtl/num_rom_reader.sv
// Read-side sequencer for the glyph ROM: issues the rows of one glyph under credit control,
// tracks the ROM read latency and streams rows out with last-row marking.
module num_rom_reader
    import num_rom_pkg::*;
#(
    parameter int unsigned  ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int unsigned  DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int unsigned  ROWS_LOG2  = ROM_ROWS_LOG2,
    parameter int unsigned  RD_LATENCY = 1,
    parameter int unsigned  FIFO_DEPTH = 4,
    localparam int unsigned IDX_W      = ADDR_WIDTH - ROWS_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_idx,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_clk_en,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    // Stage 0 is the registered ROM address; the tag leaves stage RD_LATENCY with its data.
    localparam int unsigned PIPE_N = RD_LATENCY + 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W  = $clog2(2 * FIFO_DEPTH + 2);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
            $error("num_rom_reader: RD_LATENCY must be 1 or 2");
        end
        if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
            $error("num_rom_reader: FIFO_DEPTH must be >= RD_LATENCY+1");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ROWS_LOG2-1:0]  row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  rom_clk_en_q, rom_clk_en_d;
    logic                  busy_q, busy_d;
    logic                  req_ready_q, req_ready_d;
    logic [PIPE_N-1:0]     pipe_vld_q, pipe_vld_d;
    logic [PIPE_N-1:0]     pipe_last_q, pipe_last_d;

    logic                  issue, issue_last, credit, pop, last_pop, push;
    logic [IDX_W-1:0]      issue_idx;
    logic [ROWS_LOG2-1:0]  issue_row;
    logic [CRD_W-1:0]      in_flight;
    logic [FCNT_W-1:0]     fifo_count;
    logic [DATA_WIDTH:0]   fifo_wr_data, fifo_rd_data;
    logic                  fifo_rd_valid;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < int'(PIPE_N); i++) begin
            in_flight = in_flight + CRD_W'(pipe_vld_q[i]);
        end
    end

    // A row popped this cycle frees its slot, which keeps a full pipe issuing every cycle.
    assign pop      = fifo_rd_valid & out_ready;
    assign last_pop = pop & fifo_rd_data[DATA_WIDTH];
    assign credit   = (in_flight + CRD_W'(fifo_count)) < (CRD_W'(FIFO_DEPTH) + CRD_W'(pop));
    assign push     = pipe_vld_q[PIPE_N-1];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_cnt_d    = row_cnt_q;
        rom_addr_d   = rom_addr_q;
        busy_d       = busy_q;
        issue        = 1'b0;
        issue_idx    = idx_q;
        issue_row    = row_cnt_q;
        issue_last   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Row 0 goes out on the accept cycle itself.
                if (req_valid && req_ready_q) begin
                    idx_d     = req_idx;
                    busy_d    = 1'b1;
                    issue     = 1'b1;
                    issue_idx = req_idx;
                    issue_row = '0;
                end
            end
            FETCH: begin
                issue = credit;
            end
            DRAIN: begin
                if (last_pop && (pipe_vld_q == '0)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            issue_last = (issue_row == '1);
            rom_addr_d = {issue_idx, issue_row};
            row_cnt_d  = issue_row + ROWS_LOG2'(1);
            state_d    = issue_last ? DRAIN : FETCH;
        end

        pipe_vld_d   = {pipe_vld_q[PIPE_N-2:0], issue};
        pipe_last_d  = {pipe_last_q[PIPE_N-2:0], issue_last};
        rom_clk_en_d = |pipe_vld_d[PIPE_N-2:0];
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            row_cnt_q    <= '0;
            rom_addr_q   <= '0;
            rom_clk_en_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b0;
            pipe_vld_q   <= '0;
            pipe_last_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_cnt_q    <= row_cnt_d;
            rom_addr_q   <= rom_addr_d;
            rom_clk_en_q <= rom_clk_en_d;
            busy_q       <= busy_d;
            req_ready_q  <= req_ready_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_last_q  <= pipe_last_d;
        end
    end

    assign fifo_wr_data = {pipe_last_q[PIPE_N-1], rom_rd_data};

    num_rom_reader_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_data  (fifo_wr_data),
        .rd_valid (fifo_rd_valid),
        .rd_ready (out_ready),
        .rd_data  (fifo_rd_data),
        .count_c  (fifo_count)
    );

    assign req_ready  = req_ready_q;
    assign rom_addr   = rom_addr_q;
    assign rom_clk_en = rom_clk_en_q;
    assign busy       = busy_q;
    assign out_valid  = fifo_rd_valid;
    assign out_data   = fifo_rd_data[DATA_WIDTH-1:0];
    assign out_last   = fifo_rd_data[DATA_WIDTH];

endmodule

// File: tb/tb_num_rom_reader.sv
// Scoreboard bench for num_rom_reader: two instances (ROM latency 1 and 2) share the stimulus.
module tb_num_rom_reader;
    import num_rom_pkg::*;

    localparam int unsigned AW    = ROM_ADDR_WIDTH;
    localparam int unsigned DW    = ROM_DATA_WIDTH;
    localparam int unsigned RL    = ROM_ROWS_LOG2;
    localparam int unsigned IW    = AW - RL;
    localparam int          ROWS  = 1 << RL;
    localparam int          DEPTH = 4;
    localparam int          NI    = 2;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [NI-1:0] req_valid = '0;
    logic [IW-1:0] req_idx = '0;
    logic          out_ready = 1'b0;
    int            ready_mode = 1;

    logic [NI-1:0] req_ready, rom_clk_en, out_valid, out_last, busy;
    logic [AW-1:0] rom_addr [NI];
    logic [DW-1:0] rom_rd_data [NI];
    logic [DW-1:0] out_data [NI];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // ROM image: mem[a] = a*3
    logic [DW-1:0] rom_mem [1 << AW];
    logic [DW-1:0] rom1_q, rom2a_q, rom2b_q;
    initial begin
        for (int a = 0; a < (1 << AW); a++) rom_mem[a] = DW'(a * 3);
    end
    always @(posedge clk) begin
        if (rom_clk_en[0]) rom1_q <= rom_mem[rom_addr[0]];
        if (rom_clk_en[1]) begin
            rom2a_q <= rom_mem[rom_addr[1]];
            rom2b_q <= rom2a_q;
        end
    end
    assign rom_rd_data[0] = rom1_q;
    assign rom_rd_data[1] = rom2b_q;

    num_rom_reader #(.RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_idx(req_idx), .rom_addr(rom_addr[0]), .rom_clk_en(rom_clk_en[0]),
        .rom_rd_data(rom_rd_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]));

    num_rom_reader #(.RD_LATENCY(2), .FIFO_DEPTH(DEPTH)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_idx(req_idx), .rom_addr(rom_addr[1]), .rom_clk_en(rom_clk_en[1]),
        .rom_rd_data(rom_rd_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input int inst, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s [lat%0d] at cycle %0d: got %0d, expected %0d", name, inst + 1, cyc, act, exp);
        end
    endtask

    // Scoreboard state
    row_t exp_q0[$];
    row_t exp_q1[$];
    int   acc_edge [NI];
    int   first_beat [NI];
    int   beats [NI];
    logic want_first [NI];
    logic ready_run [NI];
    logic held_vld [NI];
    logic [DW:0] held [NI];

    task automatic mon_step(input int i);
        row_t e;
        int   qsize;
        if (held_vld[i]) check("stall_hold", i, {out_valid[i], out_last[i], out_data[i]}, {1'b1, held[i]});
        held_vld[i] = out_valid[i] & ~out_ready;
        held[i]     = {out_last[i], out_data[i]};

        if (req_valid[i] && req_ready[i]) begin
            check("accept_when_idle", i, busy[i], 0);
            for (int r = 0; r < ROWS; r++) begin
                e.data = DW'((int'(req_idx) * ROWS + r) * 3);
                e.last = (r == ROWS - 1);
                if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            end
            acc_edge[i]   = cyc + 1;
            want_first[i] = 1'b1;
            ready_run[i]  = 1'b1;
            beats[i]      = 0;
        end
        if (busy[i]) begin
            check("ready_while_busy", i, req_ready[i], 0);
            if (!out_ready) ready_run[i] = 1'b0;
        end

        if (out_valid[i]) begin
            if (want_first[i]) begin
                check("first_row_latency", i, cyc - acc_edge[i], i + 2);
                want_first[i] = 1'b0;
                first_beat[i] = cyc;
            end
            if (out_ready) begin
                qsize = (i == 0) ? exp_q0.size() : exp_q1.size();
                if (qsize == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL row_without_request [lat%0d]: got data %0d last %0d, expected no row",
                             i + 1, out_data[i], out_last[i]);
                end else begin
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check("row_data", i, out_data[i], e.data);
                    check("row_last", i, out_last[i], e.last);
                    beats[i]++;
                    if (out_last[i] && ready_run[i]) check("beat_span", i, cyc - first_beat[i], ROWS - 1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            for (int i = 0; i < NI; i++) begin
                want_first[i] = 1'b0;
                ready_run[i]  = 1'b0;
                held_vld[i]   = 1'b0;
                beats[i]      = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) mon_step(i);
        end
    end

    task automatic send(input logic [IW-1:0] idx);
        logic [NI-1:0] take;
        int n;
        n = 0;
        req_idx   = idx;
        req_valid = '1;
        while (req_valid != '0 && n < 3000) begin
            @(negedge clk);
            take = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~take;
            n++;
        end
        for (int i = 0; i < NI; i++) check("accept_timeout", i, req_valid[i], 0);
        req_valid = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy != '0 || req_ready != '1) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < NI; i++) check("idle_timeout", i, {busy[i], req_ready[i]}, 1);
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < NI; i++) begin
            check("rst_req_ready", i, req_ready[i], 0);
            check("rst_rom_addr", i, rom_addr[i], 0);
            check("rst_rom_clk_en", i, rom_clk_en[i], 0);
            check("rst_out_valid", i, out_valid[i], 0);
            check("rst_out_data", i, out_data[i], 0);
            check("rst_out_last", i, out_last[i], 0);
            check("rst_busy", i, busy[i], 0);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("post_rst_req_ready", i, req_ready[i], 1);
            check("post_rst_busy", i, busy[i], 0);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        release_reset();

        // Single glyph, downstream always ready
        ready_mode = 1;
        send(IW'(5));
        wait_idle();

        // Downstream stalled: only FIFO_DEPTH rows may be fetched
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(IW'(2));
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("stall_last_addr", i, rom_addr[i], 2 * ROWS + DEPTH - 1);
            check("stall_clk_en", i, rom_clk_en[i], 0);
            check("stall_out_valid", i, out_valid[i], 1);
        end
        ready_mode = 1;
        wait_idle();

        // Request held while busy; request index changed after accept
        send(IW'(9));
        send(IW'(7));
        req_idx = IW'(12);
        wait_idle();

        // Random backpressure across a range of glyphs
        ready_mode = 2;
        for (int g = 0; g < 64; g++) begin
            send(IW'(g));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();

        // Reset in the middle of a glyph
        ready_mode = 1;
        send(IW'(3));
        n = 0;
        while (beats[0] < 6 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rows_before_reset", 0, beats[0] >= 6, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();
        send(IW'(1));
        wait_idle();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
